// File: rtl/isa_bus_master.sv
// ISA bus initiator: turns valid/ready requests into 8-bit I/O and memory cycles
// with ALE/SETUP/CMD/WAIT/HOLD phasing, RDY wait states, 0WS early termination and timeout.
module isa_bus_master #(
    parameter int ALE_CYC     = 1,
    parameter int SETUP_CYC   = 1,
    parameter int CMD_CYC     = 3,
    parameter int ZWS_CYC     = 1,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_ale,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    input  logic        bus_rdy,
    input  logic        bus_0ws_l
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ALE, ST_SETUP, ST_CMD, ST_WAIT, ST_HOLD
    } state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALE_N   = CNT_W'(ALE_CYC);
    localparam logic [CNT_W-1:0] SETUP_N = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] CMD_N   = CNT_W'(CMD_CYC);
    localparam logic [CNT_W-1:0] ZWS_N   = CNT_W'(ZWS_CYC);
    localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CYC);
    localparam logic [7:0]       TO_N    = 8'(TIMEOUT_CYC);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       wcnt_q;
    logic [1:0]       type_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rd_q;
    logic             timeout_q;
    logic [19:0]      bus_a_q;
    logic             ale_q;
    logic             aen_q;
    logic [3:0]       strb_l_q;   // index = request type: ior, iow, memr, memw
    logic [7:0]       d_out_q;
    logic             d_oe_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_rdata_q;
    logic             rsp_timeout_q;

    logic rst_meta_q, rst_n_q;
    logic rdy_meta_q, rdy_s_q;
    logic zws_meta_q, zws_s_q;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Two-flop synchronizers for the target's asynchronous handshake lines.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rdy_meta_q <= 1'b1;
            rdy_s_q    <= 1'b1;
            zws_meta_q <= 1'b1;
            zws_s_q    <= 1'b1;
        end else begin
            rdy_meta_q <= bus_rdy;
            rdy_s_q    <= rdy_meta_q;
            zws_meta_q <= bus_0ws_l;
            zws_s_q    <= zws_meta_q;
        end
    end

    logic [3:0] strb_sel;
    logic       cmd_last;
    logic       zws_exit;

    always_comb begin
        // NOTE: default first so the indexed write below cannot infer a latch.
        strb_sel         = 4'hF;
        strb_sel[type_q] = 1'b0;
    end

    assign cmd_last = (cnt_q == CMD_N);
    assign zws_exit = (cnt_q >= ZWS_N) && !zws_s_q && rdy_s_q;

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wcnt_q        <= '0;
            type_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
            timeout_q     <= 1'b0;
            bus_a_q       <= '0;
            ale_q         <= 1'b0;
            aen_q         <= 1'b1;
            strb_l_q      <= 4'hF;
            d_out_q       <= '0;
            d_oe_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        type_q  <= req_type;
                        wdata_q <= req_wdata;
                        bus_a_q <= req_addr;
                        aen_q   <= 1'b0;
                        ale_q   <= 1'b1;
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_ALE;
                    end
                end
                ST_ALE: begin
                    if (cnt_q == ALE_N) begin
                        ale_q   <= 1'b0;
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_SETUP;
                        if (type_q[0]) begin
                            d_out_q <= wdata_q;
                            d_oe_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_N) begin
                        strb_l_q <= strb_sel;
                        cnt_q    <= CNT_ONE;
                        state_q  <= ST_CMD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_CMD: begin
                    if (zws_exit || (cmd_last && rdy_s_q)) begin
                        strb_l_q  <= 4'hF;
                        rd_q      <= bus_d_in;
                        timeout_q <= 1'b0;
                        cnt_q     <= CNT_ONE;
                        state_q   <= ST_HOLD;
                    end else if (cmd_last) begin
                        wcnt_q  <= 8'd1;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    // Target readiness wins over the timeout on the final wait cycle.
                    if (rdy_s_q || (wcnt_q == TO_N)) begin
                        strb_l_q  <= 4'hF;
                        rd_q      <= bus_d_in;
                        timeout_q <= !rdy_s_q;
                        cnt_q     <= CNT_ONE;
                        state_q   <= ST_HOLD;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_N) begin
                        d_oe_q        <= 1'b0;
                        aen_q         <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= type_q[0] ? 8'h00 : rd_q;
                        rsp_timeout_q <= timeout_q;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign bus_a       = bus_a_q;
    assign bus_ale     = ale_q;
    assign bus_aen     = aen_q;
    assign bus_ior_l   = strb_l_q[0];
    assign bus_iow_l   = strb_l_q[1];
    assign bus_memr_l  = strb_l_q[2];
    assign bus_memw_l  = strb_l_q[3];
    assign bus_d_out   = d_out_q;
    assign bus_d_oe    = d_oe_q;

endmodule

// File: doc/isa_bus_master.md
Name: isa_bus_master

Overview:
- ISA bus initiator that generates 8-bit I/O and memory read/write cycles toward the card's ISA slave interface.
- Drives the address and strobes (ALE, AEN, IOR/IOW/MEMR/MEMW), drives write data, honours RDY wait states and 0WS early termination, and returns read data.
- Serves as the host-side stimulus engine for board bring-up and as the bus driver in the card-level bench.
- Fed by a simple valid/ready request port; emits a one-cycle response pulse per completed cycle.

Parameters:
- ALE_CYC, 1, cycles ALE is high at cycle start (>=1).
- SETUP_CYC, 1, cycles from ALE fall to command strobe assertion (>=1).
- CMD_CYC, 3, minimum cycles the command strobe is low (>=1).
- ZWS_CYC, 1, minimum strobe-low cycles before a 0WS termination is allowed (1..CMD_CYC).
- HOLD_CYC, 1, cycles address and write data are held after the strobe rises (>=1).
- TIMEOUT_CYC, 255, maximum extra wait-state cycles before forced termination (1..255).

Ports:
- clk  in  1  bus-domain clock; all logic on rising edge.
- reset_l  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid && req_ready.
- req_type  in  2  0=IOR, 1=IOW, 2=MEMR, 3=MEMW.
- req_addr  in  20  cycle address.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse when a cycle completes.
- rsp_rdata  out  8  read data; valid with rsp_valid for reads; 0 for writes.
- rsp_timeout  out  1  valid with rsp_valid; 1 if the cycle was force-terminated.
- bus_a  out  20  ISA address.
- bus_ale  out  1  address latch enable.
- bus_aen  out  1  address enable; 0 during initiator cycles.
- bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  active-low command strobes.
- bus_d_out  out  8  write data.
- bus_d_oe  out  1  drive enable for bus_d_out.
- bus_d_in  in  8  sampled read data.
- bus_rdy  in  1  target ready (low = insert wait states); asynchronous.
- bus_0ws_l  in  1  target zero-wait-state request; asynchronous.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all strobes 1; bus_ale 0; bus_aen 1; bus_a 0; bus_d_out 0; bus_d_oe 0.
  - rsp_valid 0; rsp_rdata 0; rsp_timeout 0; all counters 0.
  - req_ready is combinational from state, so it is 1 while in IDLE.
- Synchronizers: bus_rdy and bus_0ws_l each pass through a 2-flop synchronizer (reset value 1). All decisions use the synchronized copies (rdy_s, zws_s).
- States: IDLE, ALE, SETUP, CMD, WAIT, HOLD. Every output is registered.
- IDLE:
  - On handshake: latch type, addr and wdata; bus_a <= addr; bus_aen <= 0; go to ALE.
- ALE:
  - bus_ale = 1 for ALE_CYC cycles, then go to SETUP.
- SETUP:
  - bus_ale = 0 for SETUP_CYC cycles.
  - For writes, bus_d_out and bus_d_oe = 1 from SETUP entry through the end of HOLD.
- CMD:
  - The selected strobe goes low on CMD entry; cnt counts from 1.
  - Early exit to HOLD at the end of cycle cnt when cnt >= ZWS_CYC, zws_s = 0 and rdy_s = 1.
  - At cnt = CMD_CYC: if rdy_s = 1, go to HOLD; else go to WAIT.
- WAIT:
  - Strobe stays low; the wait counter increments each cycle.
  - Go to HOLD when rdy_s = 1.
  - When the wait count reaches TIMEOUT_CYC with rdy_s still 0, go to HOLD with the timeout flag set.
- Read capture: for reads, bus_d_in is captured in the final strobe-low cycle (the cycle that decides the HOLD transition).
- HOLD:
  - Strobe high; address and write data held for HOLD_CYC cycles.
  - Then: bus_d_oe <= 0, bus_aen <= 1, rsp_valid <= 1 for one cycle (rsp_rdata, rsp_timeout updated), state <= IDLE.
- Latency:
  - Zero-wait total = ALE_CYC + SETUP_CYC + CMD_CYC + HOLD_CYC cycles from handshake to rsp_valid; defaults give 6.
  - Each wait state adds 1 cycle.
  - Because of the synchronizer, rdy_s lags bus_rdy by 2 cycles, so a target must drop RDY within CMD_CYC-2 cycles of strobe fall to guarantee a wait state.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. Strobes are high for at least HOLD_CYC+ALE_CYC+SETUP_CYC cycles between commands.
- Exclusivity: only one strobe is ever low; ale and any strobe are never high/low together.
- Reset mid-cycle: all bus outputs return to reset values immediately (async); no rsp_valid is issued for the aborted cycle.
- req_* inputs are ignored outside IDLE. Changes to req_* during an active cycle do not affect the bus.

Test Plan:
- IOW addr=0x003B8 data=0x29, rdy held 1 -> ale high 1 cycle; bus_iow_l low exactly 3 cycles; bus_d_out=0x29 with oe high for 5 cycles; rsp_valid 6 cycles after handshake; rsp_timeout=0.
- MEMR addr=0xB0000, target returns 0x41, rdy held 1 -> bus_memr_l low 3 cycles; rsp_rdata=0x41.
- IOR addr=0x003BA, target drops bus_rdy on strobe fall for 4 cycles -> strobe low 3+wait cycles (per 2-flop sync); rsp_valid arrives that many cycles later than the zero-wait case; data captured in the last low cycle.
- MEMW with bus_0ws_l low and rdy 1 from before strobe fall (ZWS_CYC=1) -> strobe low 1 cycle; rsp_valid 4 cycles after handshake.
- IOR with bus_rdy stuck 0, TIMEOUT_CYC=4 -> strobe low CMD_CYC+4 cycles; rsp_valid with rsp_timeout=1; the next request proceeds normally.
- reset_l pulsed low during CMD of an IOW -> iow_l=1, oe=0, aen=1 in the same cycle; no rsp_valid; req_ready=1 after release; back-to-back requests then show rsp_valid and req_ready overlapping.
